// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one full-adder cell reused
// WIDTH times per operation. FSM IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle).
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input for a-b (two's complement).
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_sr, b_sr, res_sr;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              last_bit;
    logic              accept;

    // Full-adder cell: two half-adder stages plus an OR for the carry.
    logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;
    assign ha1_s = a_sr[0] ^ b_sr[0];
    assign ha1_c = a_sr[0] & b_sr[0];
    assign fa_s  = ha1_s ^ carry;
    assign ha2_c = ha1_s & carry;
    assign fa_c  = ha1_c | ha2_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    // A new operation may start from IDLE or straight out of DONE.
    assign accept   = start && (state == IDLE || state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags registered from next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Operand shift registers, carry flop, result shifter and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
`ifdef SERIAL_ADDER_SUB_EN
            b_sr   <= sub ? ~b : b;
            carry  <= sub;
`else
            b_sr   <= b;
            carry  <= 1'b0;
`endif
            res_sr <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {fa_s, res_sr[WIDTH-1:1]};
            carry  <= fa_c;
            if (!last_bit) cnt <= cnt + 1'b1;
        end
    end

    // Result outputs only change on the edge that completes the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == RUN && last_bit) begin
            sum  <= {fa_s, res_sr[WIDTH-1:1]};
            cout <= fa_c;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl (addition build, WIDTH=8).
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_chk = 0;
    int n_fail = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done (bounded), return number of edges waited; checks busy meanwhile.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 20) begin
            chk({tag, "_busy"}, busy, 1);
            tick();
            edges++;
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob);
        logic [W:0] ref_v;
        int         e;
        ref_v = {1'b0, oa} + {1'b0, ob};
        start = 1'b1; a = oa; b = ob;
        tick();
        start = 1'b0; a = ~oa; b = ~ob;
        wait_done(tag, e);
        chk({tag, "_lat"}, e, W);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy0"}, busy, 0);
        chk({tag, "_sum"}, sum, ref_v[W-1:0]);
        chk({tag, "_cout"}, cout, ref_v[W]);
        tick();
        chk({tag, "_pulse"}, done, 0);
        chk({tag, "_hold"}, sum, ref_v[W-1:0]);
    endtask

    initial begin
        int e;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        op("d3a45", 8'h3A, 8'h45);
        op("dff01", 8'hFF, 8'h01);
        op("d0000", 8'h00, 8'h00);
        op("dffff", 8'hFF, 8'hFF);
        op("d8080", 8'h80, 8'h80);

        // Back-to-back: start held with new operands during RUN.
        start = 1'b1; a = 8'h3A; b = 8'h45;
        tick();
        a = 8'h11; b = 8'h22;
        wait_done("b2b1", e);
        chk("b2b1_lat", e, W);
        chk("b2b1_sum", sum, 8'h7F);
        chk("b2b1_cout", cout, 0);
        tick();
        start = 1'b0;
        chk("b2b_nogap", busy, 1);
        wait_done("b2b2", e);
        chk("b2b2_gap", e + 1, 9);
        chk("b2b2_sum", sum, 8'h33);
        chk("b2b2_cout", cout, 0);
        tick();

        // Reset mid-RUN after 4 bits: outputs clear immediately, no done.
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        repeat (12) begin
            tick();
            if (done) e++;
        end
        chk("mid_no_done", e, 0);
        op("post_rst", 8'h10, 8'h20);

        for (int i = 0; i < 1000; i++)
            op("rnd", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
